vec_mul_sched: RTL

Sequencing controller that time-multiplexes one shared `mul_always`-style fixed-point multiplier across an N-element vector. It computes the element-wise products x[i] = a[i] * b[i], the serial counterpart of the fully parallel array-multiply top level. It owns the operand and result register banks, drives the multiplier's start/operand inputs, and collects results on the multiplier's valid strobe. It exposes the same start/valid/busy handshake as the parallel top, so either can be instantiated behind the same wrapper.

---
 rtl/vec_mul_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/vec_mul_sched.sv
// Serial element-wise vector multiply: sequences one shared multiplier over N
// operand pairs, capturing each product into the result bank on mul_valid.
module vec_mul_sched #(
  parameter int N       = 5,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   valid,
  output logic                   err,
  input  logic                   ld_en,
  input  logic [$clog2(N)-1:0]   ld_addr,
  input  logic [WIDTH-1:0]       ld_a,
  input  logic [WIDTH-1:0]       ld_b,
  output logic [N*WIDTH-1:0]     x_flat,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_start,
  input  logic [WIDTH-1:0]       mul_result,
  input  logic                   mul_valid,
  input  logic                   mul_busy,
  output logic [1:0]             dbg_state
);

  // Handshake: start is accepted only in IDLE (busy=0); valid pulses for one
  // cycle at run end with err qualifying it. Toward the multiplier, mul_start
  // fires only when mul_busy=0, and mul_valid is honoured only while waiting.

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [AW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a [N];
  logic [WIDTH-1:0] b [N];
  logic [WIDTH-1:0] x [N];
  logic             ld_ok;

  // Addresses past the last element are dropped rather than aliased.
  assign ld_ok = ({1'b0, ld_addr} < (AW+1)'(N));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a[i] <= '0;
        b[i] <= '0;
        x[i] <= '0;
      end
    end else begin
      if (ld_en && ld_ok && (state == S_IDLE)) begin
        a[ld_addr] <= ld_a;
        b[ld_addr] <= ld_b;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            err   <= 1'b0;
            idx   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!mul_busy) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mul_valid) begin
            x[idx] <= mul_result;
            if (idx == AW'(N-1)) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_ISSUE;
            end
          end else if (cnt == CW'(TIMEOUT-1)) begin
            // Abort: remaining results keep whatever the previous run left.
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset removes them without waiting a clock.
  assign busy      = (state != S_IDLE);
  assign valid     = (state == S_DONE);
  assign mul_start = (state == S_ISSUE) && !mul_busy;
  assign mul_a     = ((state == S_ISSUE) || (state == S_WAIT)) ? a[idx] : '0;
  assign mul_b     = ((state == S_ISSUE) || (state == S_WAIT)) ? b[idx] : '0;
  assign dbg_state = state;

  for (genvar g = 0; g < N; g++) begin : g_x
    assign x_flat[g*WIDTH +: WIDTH] = x[g];
  end

endmodule
